// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART sequencer: register offsets, STATUS bit
// positions, FSM state encodings and register-image helpers.
package uart_apb_pkg;

   localparam logic [4:0] ADDR_TXDATA = 5'h00;
   localparam logic [4:0] ADDR_RXDATA = 5'h04;
   localparam logic [4:0] ADDR_CTRL1  = 5'h08;
   localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
   localparam logic [4:0] ADDR_STATUS = 5'h10;
   localparam logic [4:0] ADDR_CTRL3  = 5'h14;

   localparam int ST_TXRDY = 0;
   localparam int ST_RXRDY = 1;
   localparam int ST_PE    = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_FE    = 4;

   typedef enum logic [2:0] {
      S_CFG1,
      S_CFG2,
      S_CFG3,
      S_POLL,
      S_RXRD,
      S_TXWR,
      S_GAP
   } seq_state_t;

   typedef enum logic [1:0] {
      X_IDLE,
      X_SETUP,
      X_ACCESS
   } xfer_state_t;

   // mode is {odd, par_en, bit8}
   function automatic logic [7:0] ctrl2_value(input logic [12:0] baud, input logic [2:0] mode);
      return {baud[12:8], mode};
   endfunction

   function automatic logic [7:0] ctrl3_value(input logic [2:0] frac);
      return {5'b0, frac};
   endfunction

endpackage

// File: rtl/uart_apb_xfer.sv
// Single-transfer APB master: a start in IDLE launches one SETUP/ACCESS
// transfer; done is high in the ACCESS cycle where PREADY is seen.
module uart_apb_xfer
   import uart_apb_pkg::*;
(
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       start,
   input  logic [4:0] addr,
   input  logic       wr,
   input  logic [7:0] wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic       slverr,
   output logic [4:0] PADDR,
   output logic       PSEL,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY,
   input  logic       PSLVERR
);

   xfer_state_t state_reg, state_next;
   logic [4:0]  addr_reg;
   logic        wr_reg;
   logic [7:0]  wdata_reg;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_reg <= X_IDLE;
         addr_reg  <= '0;
         wr_reg    <= 1'b0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         // Request fields are captured once so the bus stays stable for the whole transfer
         if (state_reg == X_IDLE && start) begin
            addr_reg  <= addr;
            wr_reg    <= wr;
            wdata_reg <= wdata;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         X_IDLE:   if (start) state_next = X_SETUP;
         X_SETUP:  state_next = X_ACCESS;
         X_ACCESS: if (PREADY) state_next = X_IDLE;
         default:  state_next = X_IDLE;
      endcase
   end

   assign PSEL    = (state_reg != X_IDLE);
   assign PENABLE = (state_reg == X_ACCESS);
   assign PADDR   = addr_reg;
   assign PWRITE  = wr_reg;
   assign PWDATA  = wdata_reg;
   assign done    = PENABLE && PREADY;
   assign rdata   = PRDATA;
   assign slverr  = done && PSLVERR;

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master that configures the byte UART and then shuttles bytes between
// the UART and a pair of fabric streams, collecting sticky error flags.
module uart_apb_sequencer
   import uart_apb_pkg::*;
#(
   parameter logic [12:0] BAUD_VALUE = 13'd0,
   parameter logic [2:0]  BAUD_FRAC  = 3'd0,
   parameter bit          FRAC_EN    = 1'b0,
   parameter bit          BIT8       = 1'b1,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          ODD_N_EVEN = 1'b0,
   parameter int          GAP_CYCLES = 2
)(
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        cfg_load,
   input  logic [12:0] cfg_baud,
   input  logic [2:0]  cfg_frac,
   input  logic [2:0]  cfg_mode,
   output logic        cfg_busy,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [3:0]  err_flags,
   input  logic        err_clr,
   output logic [4:0]  PADDR,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [7:0]  PWDATA,
   input  logic [7:0]  PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   localparam logic [2:0] MODE_INIT = {ODD_N_EVEN, PARITY_EN, BIT8};
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

   seq_state_t  state_reg, state_next;
   logic        issued_reg, issued_next;
   logic [3:0]  gap_cnt_reg, gap_cnt_next;
   logic        rr_reg, rr_next;
   logic        rx_full_reg, rx_full_next;
   logic [7:0]  rx_data_reg;
   logic [3:0]  err_reg, err_next;
   logic        cfg_pending_reg, cfg_pending_next;
   logic        cfg_busy_reg, cfg_busy_next;
   logic [12:0] baud_reg, baud_shadow_reg;
   logic [2:0]  frac_reg, frac_shadow_reg;
   logic [2:0]  mode_reg, mode_shadow_reg;

   logic        xfer_start;
   logic [4:0]  xfer_addr;
   logic        xfer_wr;
   logic [7:0]  xfer_wdata;
   logic        xfer_done;
   logic [7:0]  xfer_rdata;
   logic        xfer_slverr;

   logic        apply_cfg;
   logic        rx_fill;
   logic        status_done;
   logic        rx_elig;
   logic        tx_elig;
   logic [2:0]  status_err;

   uart_apb_xfer u_xfer (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .start   (xfer_start),
      .addr    (xfer_addr),
      .wr      (xfer_wr),
      .wdata   (xfer_wdata),
      .done    (xfer_done),
      .rdata   (xfer_rdata),
      .slverr  (xfer_slverr),
      .PADDR   (PADDR),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_reg       <= S_CFG1;
         issued_reg      <= 1'b0;
         gap_cnt_reg     <= '0;
         rr_reg          <= 1'b0;
         rx_full_reg     <= 1'b0;
         rx_data_reg     <= '0;
         err_reg         <= '0;
         cfg_pending_reg <= 1'b0;
         cfg_busy_reg    <= 1'b1;
         baud_reg        <= BAUD_VALUE;
         frac_reg        <= BAUD_FRAC;
         mode_reg        <= MODE_INIT;
         baud_shadow_reg <= BAUD_VALUE;
         frac_shadow_reg <= BAUD_FRAC;
         mode_shadow_reg <= MODE_INIT;
      end else begin
         state_reg       <= state_next;
         issued_reg      <= issued_next;
         gap_cnt_reg     <= gap_cnt_next;
         rr_reg          <= rr_next;
         rx_full_reg     <= rx_full_next;
         err_reg         <= err_next;
         cfg_pending_reg <= cfg_pending_next;
         cfg_busy_reg    <= cfg_busy_next;
         if (rx_fill) begin
            rx_data_reg <= xfer_rdata;
         end
         if (cfg_load) begin
            baud_shadow_reg <= cfg_baud;
            frac_shadow_reg <= cfg_frac;
            mode_shadow_reg <= cfg_mode;
         end
         if (apply_cfg) begin
            baud_reg <= baud_shadow_reg;
            frac_reg <= frac_shadow_reg;
            mode_reg <= mode_shadow_reg;
         end
      end
   end

   assign rx_elig = xfer_rdata[ST_RXRDY] && !rx_full_reg;
   assign tx_elig = xfer_rdata[ST_TXRDY] && tx_valid;

   always_comb begin
      state_next   = state_reg;
      gap_cnt_next = gap_cnt_reg;
      rr_next      = rr_reg;
      xfer_start   = 1'b0;
      xfer_addr    = ADDR_STATUS;
      xfer_wr      = 1'b0;
      xfer_wdata   = '0;
      apply_cfg    = 1'b0;
      rx_fill      = 1'b0;
      status_done  = 1'b0;
      tx_ready     = 1'b0;
      case (state_reg)
         S_CFG1: begin
            xfer_start = !issued_reg;
            xfer_addr  = ADDR_CTRL1;
            xfer_wr    = 1'b1;
            xfer_wdata = baud_reg[7:0];
            if (xfer_done) state_next = S_CFG2;
         end
         S_CFG2: begin
            xfer_start = !issued_reg;
            xfer_addr  = ADDR_CTRL2;
            xfer_wr    = 1'b1;
            xfer_wdata = ctrl2_value(baud_reg, mode_reg);
            if (xfer_done) state_next = FRAC_EN ? S_CFG3 : S_POLL;
         end
         S_CFG3: begin
            xfer_start = !issued_reg;
            xfer_addr  = ADDR_CTRL3;
            xfer_wr    = 1'b1;
            xfer_wdata = ctrl3_value(frac_reg);
            if (xfer_done) state_next = S_POLL;
         end
         S_POLL: begin
            xfer_start  = !issued_reg;
            status_done = xfer_done;
            if (xfer_done) begin
               // A queued reconfiguration beats both data directions
               if (cfg_pending_reg) begin
                  apply_cfg  = 1'b1;
                  state_next = S_CFG1;
               end else if (rx_elig && (!tx_elig || !rr_reg)) begin
                  state_next = S_RXRD;
               end else if (tx_elig) begin
                  state_next = S_TXWR;
               end
            end
         end
         S_RXRD: begin
            xfer_start = !issued_reg;
            xfer_addr  = ADDR_RXDATA;
            if (xfer_done) begin
               rx_fill      = 1'b1;
               rr_next      = !rr_reg;
               gap_cnt_next = GAP_LOAD;
               state_next   = S_GAP;
            end
         end
         S_TXWR: begin
            xfer_start = !issued_reg;
            xfer_addr  = ADDR_TXDATA;
            xfer_wr    = 1'b1;
            xfer_wdata = tx_data;
            tx_ready   = xfer_done;
            if (xfer_done) begin
               rr_next      = !rr_reg;
               gap_cnt_next = GAP_LOAD;
               state_next   = S_GAP;
            end
         end
         S_GAP: begin
            // The last gap cycle launches the STATUS poll, so the bus idles exactly GAP_CYCLES
            if (gap_cnt_reg == 4'd0) begin
               xfer_start = 1'b1;
               state_next = S_POLL;
            end else begin
               gap_cnt_next = gap_cnt_reg - 4'd1;
            end
         end
         default: state_next = S_CFG1;
      endcase
   end

   assign issued_next = xfer_done ? 1'b0 : (issued_reg || xfer_start);

   assign status_err   = status_done ? {xfer_rdata[ST_FE], xfer_rdata[ST_OVF], xfer_rdata[ST_PE]} : 3'b0;
   assign err_next     = (err_clr ? 4'b0 : err_reg) | {xfer_slverr, status_err};
   assign rx_full_next = rx_fill || (rx_full_reg && !rx_ready);

   assign cfg_pending_next = cfg_load || (cfg_pending_reg && !apply_cfg);
   assign cfg_busy_next    = cfg_pending_next || (state_next == S_CFG1) ||
                             (state_next == S_CFG2) || (state_next == S_CFG3);

   assign cfg_busy  = cfg_busy_reg;
   assign rx_valid  = rx_full_reg;
   assign rx_data   = rx_data_reg;
   assign err_flags = err_reg;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: an APB UART slave model, a bus/stream
// scoreboard monitor and a stimulus sequence covering config, RX, TX and errors.
module tb_uart_apb_sequencer;

   localparam int GAP = 2;

   typedef struct packed {
      logic [4:0] addr;
      logic       wr;
      logic [7:0] wdata;
   } xfer_t;

   logic        PCLK;
   logic        PRESET;
   logic        cfg_load;
   logic [12:0] cfg_baud;
   logic [2:0]  cfg_frac;
   logic [2:0]  cfg_mode;
   logic        cfg_busy;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [3:0]  err_flags;
   logic        err_clr;
   logic [4:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PWDATA;
   logic [7:0]  PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   logic [7:0]  status_val;
   logic [7:0]  rxdata_val;
   int          stall_tx;
   logic        pslverr_en;
   int          acc_cnt;

   xfer_t       exp_q[$];
   logic [7:0]  rx_q[$];
   int          checks;
   int          errors;
   int          poll_count;
   int          last_tx_enables;

   uart_apb_sequencer #(
      .BAUD_VALUE (13'h145),
      .FRAC_EN    (1'b0),
      .GAP_CYCLES (GAP)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cfg_load  (cfg_load),
      .cfg_baud  (cfg_baud),
      .cfg_frac  (cfg_frac),
      .cfg_mode  (cfg_mode),
      .cfg_busy  (cfg_busy),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .err_flags (err_flags),
      .err_clr   (err_clr),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Slave model: TXDATA writes can be stalled, everything else answers at once
   assign PREADY  = PENABLE && (acc_cnt >= (((PADDR == 5'h00) && PWRITE) ? stall_tx : 0));
   assign PRDATA  = (PADDR == 5'h10) ? status_val : (PADDR == 5'h04) ? rxdata_val : 8'h00;
   assign PSLVERR = pslverr_en && PENABLE && PREADY;

   always @(posedge PCLK) begin
      if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic wait_queue_empty(input int max_cycles, input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check(name, 16'(exp_q.size()), 16'd0);
   endtask

   task automatic wait_tx_ready(input int max_cycles, input string name);
      int n;
      n = 0;
      @(negedge PCLK);
      while (!tx_ready && n < max_cycles) begin
         @(negedge PCLK);
         n++;
      end
      check(name, {15'd0, tx_ready}, 16'd1);
   endtask

   // Bus and stream monitor
   initial begin
      xfer_t       e;
      logic [4:0]  s_addr;
      logic        s_wr;
      logic [7:0]  s_wdata;
      int          en_cnt;
      int          idle_cnt;
      logic        last_data;
      logic        rxv_pending;
      logic        busy_pending;
      logic        comp;
      logic        txdone;
      logic [7:0]  r;
      en_cnt = 0; idle_cnt = 0; last_data = 0; rxv_pending = 0; busy_pending = 0;
      s_addr = '0; s_wr = 0; s_wdata = '0;
      forever begin
         @(negedge PCLK);
         if (PRESET) begin
            idle_cnt = 0; last_data = 0; rxv_pending = 0; busy_pending = 0;
         end else begin
            if (rxv_pending) begin
               check("rx_valid_rise", {15'd0, rx_valid}, 16'd1);
               rxv_pending = 0;
            end
            if (busy_pending) begin
               check("cfg_busy_fall", {15'd0, cfg_busy}, 16'd0);
               busy_pending = 0;
            end
            if (rx_valid && rx_ready) begin
               if (rx_q.size() == 0) begin
                  check("rx_unexpected", {8'd0, rx_data}, 16'hFFFF);
               end else begin
                  r = rx_q.pop_front();
                  check("rx_byte", {8'd0, rx_data}, {8'd0, r});
                  $display("rx byte 0x%02h", rx_data);
               end
            end
            comp   = PSEL && PENABLE && PREADY;
            txdone = comp && (PADDR == 5'h00) && PWRITE;
            if (tx_ready || txdone) check("tx_ready_pulse", {15'd0, tx_ready}, {15'd0, txdone});
            if (!PSEL) begin
               idle_cnt++;
            end else if (!PENABLE) begin
               if (last_data) check("gap_idle", 16'(idle_cnt), 16'(GAP));
               else check("idle_min", {15'd0, (idle_cnt >= 1)}, 16'd1);
               s_addr = PADDR; s_wr = PWRITE; s_wdata = PWDATA;
               en_cnt = 0;
            end else begin
               en_cnt++;
               check("bus_stable", {2'b0, PADDR, PWRITE, PWDATA}, {2'b0, s_addr, s_wr, s_wdata});
               if (comp) begin
                  idle_cnt = 0;
                  last_data = (PADDR == 5'h04) || (PADDR == 5'h00);
                  if (PADDR == 5'h10) begin
                     check("status_is_read", {15'd0, PWRITE}, 16'd0);
                     poll_count++;
                  end else begin
                     $display("xfer addr=0x%02h wr=%0d wdata=0x%02h", PADDR, PWRITE, PWDATA);
                     if (exp_q.size() == 0) begin
                        check("xfer_unexpected", {2'b0, PADDR, PWRITE, PWDATA}, 16'hFFFF);
                     end else begin
                        e = exp_q.pop_front();
                        check("xfer", {2'b0, PADDR, PWRITE, PWRITE ? PWDATA : 8'h00},
                              {2'b0, e.addr, e.wr, e.wdata});
                     end
                  end
                  if (PADDR == 5'h04 && !PWRITE) begin
                     check("rx_slot_empty_at_read", {15'd0, rx_valid}, 16'd0);
                     rxv_pending = 1;
                  end
                  if (PADDR == 5'h0C && PWRITE) busy_pending = 1;
                  if (txdone) last_tx_enables = en_cnt;
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      checks = 0; errors = 0; poll_count = 0; last_tx_enables = 0;
      PRESET = 1; cfg_load = 0; cfg_baud = '0; cfg_frac = '0; cfg_mode = '0;
      tx_data = '0; tx_valid = 0; rx_ready = 0; err_clr = 0;
      status_val = 8'h00; rxdata_val = 8'h00; stall_tx = 0; pslverr_en = 0;

      // Reset state and start-up configuration
      exp_q.push_back('{5'h08, 1'b1, 8'h45});
      exp_q.push_back('{5'h0C, 1'b1, 8'h09});
      repeat (3) tick();
      @(negedge PCLK);
      check("reset_outputs", {PSEL, PENABLE, PWRITE, tx_ready, rx_valid, err_flags, cfg_busy},
            {7'd0, 4'h0, 1'b1});
      check("reset_paddr_pwdata", {3'b0, PADDR, PWDATA}, 16'd0);
      tick();
      PRESET = 0;
      wait_queue_empty(100, "startup_config");
      begin
         int n;
         n = 0;
         while (poll_count == 0 && n < 50) begin tick(); n++; end
      end
      check("polls_started", {15'd0, (poll_count > 0)}, 16'd1);
      check("cfg_busy_idle", {15'd0, cfg_busy}, 16'd0);

      // Single RX byte held while the consumer stalls
      rxdata_val = 8'hA5;
      exp_q.push_back('{5'h04, 1'b0, 8'h00});
      rx_q.push_back(8'hA5);
      status_val = 8'h02;
      wait_queue_empty(100, "rx_read");
      repeat (60) tick();
      check("rx_held", {7'd0, rx_valid, rx_data}, {7'd0, 1'b1, 8'hA5});
      status_val = 8'h00;
      repeat (6) tick();
      rx_ready = 1;
      tick();
      rx_ready = 0;
      repeat (2) tick();
      check("rx_drained", {15'd0, rx_valid}, 16'd0);
      check("rx_q_empty", 16'(rx_q.size()), 16'd0);

      // Fresh reset, then RX/TX alternation starting with RX
      PRESET = 1;
      exp_q.push_back('{5'h08, 1'b1, 8'h45});
      exp_q.push_back('{5'h0C, 1'b1, 8'h09});
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{5'h04, 1'b0, 8'h00});
         exp_q.push_back('{5'h00, 1'b1, 8'h3C});
         rx_q.push_back(8'h5A);
      end
      status_val = 8'h03; rxdata_val = 8'h5A; tx_data = 8'h3C; tx_valid = 1; rx_ready = 1;
      repeat (2) tick();
      @(negedge PCLK);
      check("reset_midrun", {PSEL, rx_valid, err_flags, cfg_busy}, {2'b0, 4'h0, 1'b1});
      tick();
      PRESET = 0;
      wait_queue_empty(400, "alternation");
      tx_valid = 0; status_val = 8'h00;
      repeat (10) tick();
      rx_ready = 0;
      check("alt_rx_q_empty", 16'(rx_q.size()), 16'd0);

      // TXDATA write with PREADY held low for 3 ACCESS cycles
      stall_tx = 3; status_val = 8'h01; tx_data = 8'h77;
      exp_q.push_back('{5'h00, 1'b1, 8'h77});
      tx_valid = 1;
      wait_tx_ready(100, "stall_tx_ready");
      tick();
      tx_valid = 0;
      check("stall_penable_cycles", 16'(last_tx_enables), 16'd4);
      wait_queue_empty(50, "stall_write");

      // Sticky errors and clear
      check("err_before", {12'd0, err_flags}, 16'h0000);
      status_val = 8'h1C; pslverr_en = 1;
      repeat (20) tick();
      check("err_set", {12'd0, err_flags}, 16'h000F);
      status_val = 8'h00; pslverr_en = 0;
      repeat (8) tick();
      check("err_sticky", {12'd0, err_flags}, 16'h000F);
      err_clr = 1;
      tick();
      err_clr = 0;
      repeat (2) tick();
      check("err_cleared", {12'd0, err_flags}, 16'h0000);

      // cfg_load arriving during a stalled TXDATA write
      exp_q.push_back('{5'h00, 1'b1, 8'h3C});
      exp_q.push_back('{5'h08, 1'b1, 8'hFF});
      exp_q.push_back('{5'h0C, 1'b1, 8'h01});
      tx_data = 8'h3C; status_val = 8'h01; tx_valid = 1;
      begin
         int n;
         n = 0;
         @(negedge PCLK);
         while (!(PSEL && PENABLE && PADDR == 5'h00) && n < 100) begin
            @(negedge PCLK);
            n++;
         end
      end
      check("tx_in_flight", {15'd0, (PSEL && PENABLE && PADDR == 5'h00)}, 16'd1);
      tick();
      cfg_load = 1; cfg_baud = 13'h0FF; cfg_frac = 3'd0; cfg_mode = 3'b001;
      @(negedge PCLK);
      check("busy_at_load", {15'd0, cfg_busy}, 16'd0);
      tick();
      cfg_load = 0;
      @(negedge PCLK);
      check("busy_after_load", {15'd0, cfg_busy}, 16'd1);
      wait_tx_ready(50, "load_tx_ready");
      tick();
      tx_valid = 0;
      check("busy_during_seq", {15'd0, cfg_busy}, 16'd1);
      wait_queue_empty(100, "reconfig");
      repeat (4) tick();
      check("busy_done", {15'd0, cfg_busy}, 16'd0);

      repeat (10) tick();
      check("final_rx_q", 16'(rx_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
